// File: rtl/seq_accumulator_if.sv
// seq_accumulator_if: beat-in / packet-result-out handshake bundle for seq_accumulator
interface seq_accumulator_if #(
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/seq_accumulator.sv
// seq_accumulator: sums a packet of byte beats into a 16-bit result with beat count and overflow flag
module ripple_carry_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);
  logic [W:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign cout = c[W];
endmodule

module seq_accumulator #(
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  seq_accumulator_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [1:0]       state_q, state_d;
  logic [7:0]       acc_lo_q, acc_lo_d;
  logic [7:0]       acc_hi_q, acc_hi_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       sum_lo;
  logic             carry;
  logic             in_rdy, out_vld, accept, take;
  ripple_carry_adder #(.W(8)) u_add (
    .a   (acc_lo_q),
    .b   (bus.in_data),
    .cin (1'b0),
    .sum (sum_lo),
    .cout(carry)
  );
  assign in_rdy        = state_q != DONE;
  assign out_vld       = state_q == DONE;
  assign accept        = bus.in_valid && in_rdy;
  assign take          = out_vld && bus.out_ready;
  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.out_sum   = out_vld ? {acc_hi_q, acc_lo_q} : 16'd0;
  assign bus.out_count = out_vld ? count_q : '0;
  assign bus.out_ovf   = out_vld && ovf_q;
  // next state: clear on result handshake, otherwise accumulate an accepted beat
  always_comb begin
    state_d  = state_q;
    acc_lo_d = acc_lo_q;
    acc_hi_d = acc_hi_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (take) begin
      state_d  = IDLE;
      acc_lo_d = 8'd0;
      acc_hi_d = 8'd0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (accept) begin
      acc_lo_d = sum_lo;
      acc_hi_d = acc_hi_q + {7'd0, carry};
      ovf_d    = ovf_q | (carry && acc_hi_q == 8'hFF);
      count_d  = state_q == IDLE ? CNT_W'(1) : (count_q == CNT_MAX ? count_q : count_q + CNT_W'(1));
      state_d  = bus.in_last ? DONE : ACC;
    end
  end
  // registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_lo_q <= 8'd0;
      acc_hi_q <= 8'd0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_lo_q <= acc_lo_d;
      acc_hi_q <= acc_hi_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_seq_accumulator.sv
// tb_seq_accumulator: directed and random checks of seq_accumulator against a packet-level model
module tb_seq_accumulator;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seq_accumulator_if #(.CNT_W(8)) bus();
  seq_accumulator #(.CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  int checks = 0;
  int errors = 0;
  bit          m_done = 1'b0;
  int unsigned m_beats[$];
  logic [15:0] m_sum = '0;
  logic [7:0]  m_cnt = '0;
  logic        m_ovf = 1'b0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic close_packet();
    int unsigned tot = 0;
    foreach (m_beats[k]) tot += m_beats[k];
    m_sum  = tot[15:0];
    m_ovf  = tot > 65535;
    m_cnt  = m_beats.size() > 255 ? 8'hFF : 8'(m_beats.size());
    m_done = 1'b1;
    m_beats.delete();
  endtask
  task automatic cyc(input logic v, input logic [7:0] d, input logic l, input logic ordy, input logic rn);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.out_ready = ordy;
    rst_n         = rn;
    @(negedge clk);
    chk("in_ready", 32'(bus.in_ready), 32'(!m_done));
    chk("out_valid", 32'(bus.out_valid), 32'(m_done));
    chk("out_sum", 32'(bus.out_sum), m_done ? 32'(m_sum) : 32'd0);
    chk("out_count", 32'(bus.out_count), m_done ? 32'(m_cnt) : 32'd0);
    chk("out_ovf", 32'(bus.out_ovf), m_done ? 32'(m_ovf) : 32'd0);
    if (!rn) begin
      m_done = 1'b0;
      m_beats.delete();
    end else if (m_done) begin
      if (ordy) m_done = 1'b0;
    end else if (v) begin
      m_beats.push_back(32'(d));
      if (l) close_packet();
    end
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] d, input logic l);
    cyc(1'b1, d, l, 1'b0, 1'b1);
  endtask
  task automatic take();
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask
  task automatic expect_res(input string tag, input logic [15:0] s, input logic [7:0] c, input logic o);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.out_sum), 32'(s));
    chk({tag, "_count"}, 32'(bus.out_count), 32'(c));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(o));
  endtask
  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b1);
    expect_res("three", 16'h0060, 8'd3, 1'b0);
    take();
    beat(8'hAB, 1'b1);
    expect_res("single", 16'h00AB, 8'd1, 1'b0);
    chk("single_in_ready", 32'(bus.in_ready), 32'd0);
    take();
    beat(8'hFF, 1'b0);
    beat(8'h01, 1'b1);
    expect_res("carry1", 16'h0100, 8'd2, 1'b0);
    take();
    for (int i = 0; i < 4; i++) beat(8'hFF, i == 3);
    expect_res("carry4", 16'h03FC, 8'd4, 1'b0);
    take();
    for (int i = 0; i < 258; i++) beat(8'hFF, i == 257);
    expect_res("ovf", 16'h00FE, 8'hFF, 1'b1);
    take();
    chk("after_take_valid", 32'(bus.out_valid), 32'd0);
    beat(8'h11, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b1);
    expect_res("bp_hold", 16'h0011, 8'd1, 1'b0);
    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    take();
    beat(8'h22, 1'b1);
    expect_res("bp_fresh", 16'h0022, 8'd1, 1'b0);
    take();
    beat(8'h05, 1'b0);
    beat(8'h06, 1'b0);
    cyc(1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
    beat(8'h07, 1'b1);
    expect_res("rst_mid", 16'h0007, 8'd1, 1'b0);
    take();
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) != 0, $urandom_range(0, 63) != 0);
    take();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_accumulator.md
SEQ_ACCUMULATOR -- requirements
Module: seq_accumulator

Interface
REQ-001 Parameter CNT_W, default 8, width of the beat counter and out_count.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the clk rising edge.
REQ-004 in_valid  input  1  upstream beat valid.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 in_data  input  8  unsigned operand.
REQ-007 in_last  input  1  marks the final beat of a packet; qualified by in_valid.
REQ-008 out_valid  output  1  packet result available.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_sum  output  16  unsigned sum of all packet beats, modulo 2^16.
REQ-011 out_count  output  CNT_W  number of beats in the packet, saturating.
REQ-012 out_ovf  output  1  packet sum exceeded 0xFFFF.

Function
REQ-013 Beat accepted iff in_valid && in_ready in the same cycle; result taken iff out_valid && out_ready.
REQ-014 Low-byte addition SHALL use one ripple_carry_adder instance (8-bit, carry-in 0): a = acc_lo, b = in_data, sum -> next acc_lo, cout -> carry.
REQ-015 High byte: acc_hi <= acc_hi + carry, 8-bit wrap; wrap 0xFF->0x00 with carry=1 sets sticky ovf.
REQ-016 FSM states: IDLE, ACC, DONE; encoding free.
REQ-017 IDLE: in_ready=1, out_valid=0; on accept: accumulate, count <= 1; in_last=1 -> DONE, else -> ACC.
REQ-018 ACC: in_ready=1, out_valid=0; on accept: accumulate, count += 1 (saturate at 2^CNT_W-1, no wrap); in_last=1 -> DONE; no accept -> stay, state unchanged.
REQ-019 DONE: in_ready=0, out_valid=1; out_sum={acc_hi,acc_lo}, out_count, out_ovf stable while out_ready=0.
REQ-020 DONE with out_ready=1: -> IDLE next cycle; acc_lo, acc_hi, count, ovf cleared to 0 in the same edge.
REQ-021 Latency: last beat accepted at edge t -> out_valid=1 after edge t (first cycle after acceptance); no combinational path in->out.
REQ-022 No overlap: first beat of the next packet is accepted no earlier than the cycle after the result handshake.
REQ-023 in_data and in_last are ignored when in_valid=0 or in_ready=0.
REQ-024 out_sum, out_count, out_ovf are 0 whenever out_valid=0.
REQ-025 Throughput: one beat per cycle in IDLE/ACC; one packet per (beats + 1) cycles minimum.

Reset
REQ-026 rst_n=0 at an edge: state -> IDLE, acc_lo=acc_hi=count=ovf=0, out_valid=0, in_ready=1 the following cycle.
REQ-027 Reset overrides any simultaneous beat or result handshake; a partial packet is discarded, with no result emitted.
REQ-028 No state is kept across reset; the first beat after reset starts a new packet.

Verification
REQ-029 Beats 0x10, 0x20, 0x30(last), back-to-back -> one cycle later out_valid=1, out_sum=0x0060, out_count=3, out_ovf=0.
REQ-030 Single beat 0xAB with in_last=1 -> next cycle out_sum=0x00AB, out_count=1, in_ready=0.
REQ-031 Carry: 0xFF, 0x01(last) -> out_sum=0x0100; 0xFF x4(last on 4th) -> out_sum=0x03FC.
REQ-032 Overflow: 258 beats of 0xFF -> out_sum=0x00FE (65790 mod 65536), out_ovf=1, out_count=0xFF (saturated, CNT_W=8).
REQ-033 Backpressure: after result, out_ready=0 for 5 cycles while in_valid=1 -> outputs constant, in_ready=0, no beat consumed; out_ready=1 -> IDLE, next beat starts a fresh sum.
REQ-034 Reset mid-packet: 0x05, 0x06 accepted, rst_n=0 one cycle, then 0x07(last) -> out_sum=0x0007, out_count=1.
